// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline control bus: stage handshake inputs, decode operand fields,
// and the valid/allowin/hazard/bypass results.
interface pipe_hazard_ctrl_if #(
  parameter int NSTAGE = 5,
  parameter int AW     = 5,
  parameter int DW     = 32
);
  logic                 if_valid;
  logic [NSTAGE-1:0]    ready_go;
  logic                 flush;
  logic [AW-1:0]        id_rs1;
  logic [AW-1:0]        id_rs2;
  logic                 id_rs1_en;
  logic                 id_rs2_en;
  logic [AW-1:0]        id_rd;
  logic                 id_rd_we;
  logic                 id_is_load;
  logic [NSTAGE*DW-1:0] stage_wdata;
  logic [NSTAGE-1:0]    stage_valid;
  logic [NSTAGE-1:0]    allowin;
  logic                 id_stall;
  logic                 fwd_rs1_hit;
  logic                 fwd_rs2_hit;
  logic [DW-1:0]        fwd_rs1_data;
  logic [DW-1:0]        fwd_rs2_data;

  modport master (
    output if_valid, ready_go, flush, id_rs1, id_rs2, id_rs1_en, id_rs2_en,
           id_rd, id_rd_we, id_is_load, stage_wdata,
    input  stage_valid, allowin, id_stall, fwd_rs1_hit, fwd_rs2_hit,
           fwd_rs1_data, fwd_rs2_data
  );

  modport slave (
    input  if_valid, ready_go, flush, id_rs1, id_rs2, id_rs1_en, id_rs2_en,
           id_rd, id_rd_we, id_is_load, stage_wdata,
    output stage_valid, allowin, id_stall, fwd_rs1_hit, fwd_rs2_hit,
           fwd_rs1_data, fwd_rs2_data
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline backbone: stage valids, allowin chain, destination tracking and RAW stall.
// Define PIPE_HAZARD_FWD_EN to build the bypass network; otherwise every RAW match stalls.
module pipe_hazard_ctrl #(
  parameter int NSTAGE      = 5,
  parameter int AW          = 5,
  parameter int DW          = 32,
  parameter int LD_STAGE    = 3,
  parameter int FLUSH_DEPTH = 1
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  logic [NSTAGE-1:1]         valid;
  logic [NSTAGE-1:2][AW-1:0] tab_rd;
  logic [NSTAGE-1:2]         tab_we;
  logic [NSTAGE-1:2]         tab_ld;

  logic [NSTAGE-1:0] sv;
  logic [NSTAGE-1:0] rg;
  logic [NSTAGE-1:0] allow;
  logic              chain;
  logic              stall;

  logic [1:0][AW-1:0] rs;
  logic [1:0]         rs_en;
  logic [1:0]         m_any;

  assign sv    = {valid, bus.if_valid};
  assign rs    = {bus.id_rs2, bus.id_rs1};
  assign rs_en = {bus.id_rs2_en, bus.id_rs1_en};

  always_comb begin
    rg    = bus.ready_go;
    rg[1] = bus.ready_go[1] & ~stall;
    allow = '0;
    chain = 1'b1;
    for (int i = NSTAGE-1; i >= 0; i--) begin
      allow[i] = ~sv[i] | (rg[i] & chain);
      chain    = allow[i];
    end
  end

`ifdef PIPE_HAZARD_FWD_EN
  logic [1:0]         m_ok;
  logic [1:0][DW-1:0] m_data;
  logic [1:0]         fwd_hit;
`endif

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    m_any = '0;
`ifdef PIPE_HAZARD_FWD_EN
    m_ok   = '0;
    m_data = '0;
`endif
    for (int s = 0; s < 2; s++) begin
      for (int j = NSTAGE-1; j >= 2; j--) begin
        if (valid[1] & rs_en[s] & valid[j] & tab_we[j] & (tab_rd[j] == rs[s])) begin
          m_any[s] = 1'b1;
`ifdef PIPE_HAZARD_FWD_EN
          m_ok[s]   = bus.ready_go[j] & ~(tab_ld[j] & (j < LD_STAGE));
          m_data[s] = bus.stage_wdata[j*DW +: DW];
`endif
        end
      end
    end
  end

`ifdef PIPE_HAZARD_FWD_EN
  assign stall            = |(m_any & ~m_ok);
  assign fwd_hit          = m_any & m_ok;
  assign bus.fwd_rs1_hit  = fwd_hit[0];
  assign bus.fwd_rs2_hit  = fwd_hit[1];
  assign bus.fwd_rs1_data = fwd_hit[0] ? m_data[0] : '0;
  assign bus.fwd_rs2_data = fwd_hit[1] ? m_data[1] : '0;

  logic unused_wdata;
  assign unused_wdata = ^bus.stage_wdata[2*DW-1:0];
`else
  assign stall            = |m_any;
  assign bus.fwd_rs1_hit  = 1'b0;
  assign bus.fwd_rs2_hit  = 1'b0;
  assign bus.fwd_rs1_data = '0;
  assign bus.fwd_rs2_data = '0;

  logic unused_fwd;
  assign unused_fwd = ^{bus.stage_wdata, tab_ld};
`endif

  assign bus.stage_valid = sv;
  assign bus.allowin     = allow;
  assign bus.id_stall    = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= '0;
      tab_we <= '0;
    end else begin
      for (int i = 1; i < NSTAGE; i++)
        if (allow[i]) valid[i] <= sv[i-1] & rg[i-1];
      if (allow[2]) begin
        tab_rd[2] <= bus.id_rd;
        tab_we[2] <= bus.id_rd_we & (bus.id_rd != '0) & sv[1] & rg[1];
        tab_ld[2] <= bus.id_is_load;
      end
      for (int j = 3; j < NSTAGE; j++) begin
        if (allow[j]) begin
          tab_rd[j] <= tab_rd[j-1];
          tab_we[j] <= tab_we[j-1];
          tab_ld[j] <= tab_ld[j-1];
        end
      end
      // Squash overrides advance in the young stages only.
      if (bus.flush) begin
        for (int i = 1; i <= FLUSH_DEPTH; i++) valid[i] <= 1'b0;
        for (int i = 2; i <= FLUSH_DEPTH; i++) tab_we[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: instruction-slot reference model predicts every cycle's outputs.
module tb_pipe_hazard_ctrl;
  localparam int NSTAGE      = 5;
  localparam int AW          = 5;
  localparam int DW          = 32;
  localparam int LD_STAGE    = 3;
  localparam int FLUSH_DEPTH = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NSTAGE(NSTAGE), .AW(AW), .DW(DW)) bus ();

  pipe_hazard_ctrl #(
    .NSTAGE(NSTAGE), .AW(AW), .DW(DW), .LD_STAGE(LD_STAGE), .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  typedef struct {
    logic [AW-1:0] rs1, rs2, rd;
    bit            en1, en2, we, ld;
    logic [DW-1:0] data;
  } inst_t;

  typedef struct {
    logic [NSTAGE-1:0] sv, al;
    bit                st, h1, h2;
    logic [DW-1:0]     d1, d2;
  } exp_t;

  inst_t m_slot[NSTAGE];
  bit    m_v[NSTAGE];
  inst_t if_inst;
  inst_t dir_q[$];
  bit    dmode;

  bit                c_ifv, c_fl, c_rst, n_ifv, n_fl, n_rst;
  logic [NSTAGE-1:0] c_rg, n_rg;
  logic [NSTAGE-1:0] e_al, e_sv, e_rgeff;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errs = 0;
  int   checks = 0;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endfunction

  function automatic inst_t rand_inst();
    inst_t x;
    x.rs1  = AW'($urandom_range(0, 3));
    x.rs2  = AW'($urandom_range(0, 3));
    x.rd   = AW'($urandom_range(0, 3));
    x.en1  = $urandom_range(0, 1) == 1;
    x.en2  = $urandom_range(0, 1) == 1;
    x.we   = $urandom_range(0, 3) != 0;
    x.ld   = $urandom_range(0, 3) == 0;
    x.data = $urandom;
    return x;
  endfunction

  function automatic inst_t mk(int rd, bit we, bit ld, int rs1, bit en1, int rs2, bit en2);
    inst_t x;
    x.rd = AW'(rd); x.we = we; x.ld = ld;
    x.rs1 = AW'(rs1); x.en1 = en1; x.rs2 = AW'(rs2); x.en2 = en2;
    x.data = $urandom;
    return x;
  endfunction

  // Drive this cycle's inputs and push the outputs the model expects for them.
  task automatic apply();
    exp_t          e;
    int            jj;
    bit            found, en, a;
    logic [AW-1:0] rs;
    c_ifv = n_ifv; c_rg = n_rg; c_fl = n_fl; c_rst = n_rst;
    if (dmode) begin
      c_ifv = dir_q.size() > 0;
      if (c_ifv) if_inst = dir_q[0];
    end
    reset        = c_rst;
    bus.if_valid = c_ifv;
    bus.ready_go = c_rg;
    bus.flush    = c_fl;
    if (m_v[1]) begin
      bus.id_rs1 = m_slot[1].rs1;  bus.id_rs1_en = m_slot[1].en1;
      bus.id_rs2 = m_slot[1].rs2;  bus.id_rs2_en = m_slot[1].en2;
      bus.id_rd  = m_slot[1].rd;   bus.id_rd_we  = m_slot[1].we;
      bus.id_is_load = m_slot[1].ld;
    end else begin
      bus.id_rs1 = AW'($urandom); bus.id_rs1_en = $urandom_range(0, 1) == 1;
      bus.id_rs2 = AW'($urandom); bus.id_rs2_en = $urandom_range(0, 1) == 1;
      bus.id_rd  = AW'($urandom); bus.id_rd_we  = $urandom_range(0, 1) == 1;
      bus.id_is_load = $urandom_range(0, 1) == 1;
    end
    for (int j = 0; j < NSTAGE; j++)
      bus.stage_wdata[j*DW +: DW] = (j >= 2 && m_v[j]) ? m_slot[j].data : $urandom;

    e.sv = '0; e.sv[0] = c_ifv;
    for (int i = 1; i < NSTAGE; i++) e.sv[i] = m_v[i];
    e.st = 0; e.h1 = 0; e.h2 = 0; e.d1 = '0; e.d2 = '0;
    for (int s = 0; s < 2; s++) begin
      rs = (s == 0) ? m_slot[1].rs1 : m_slot[1].rs2;
      en = (s == 0) ? m_slot[1].en1 : m_slot[1].en2;
      found = 0; jj = 0;
      if (m_v[1] && en)
        for (int j = 2; j < NSTAGE; j++)
          if (!found && m_v[j] && m_slot[j].we && m_slot[j].rd != 0 && m_slot[j].rd == rs) begin
            found = 1; jj = j;
          end
      if (found) begin
`ifdef PIPE_HAZARD_FWD_EN
        if (!c_rg[jj] || (m_slot[jj].ld && jj < LD_STAGE)) e.st = 1;
        else if (s == 0) begin e.h1 = 1; e.d1 = m_slot[jj].data; end
        else begin e.h2 = 1; e.d2 = m_slot[jj].data; end
`else
        e.st = 1;
`endif
      end
    end
    e_rgeff = c_rg;
    if (e.st) e_rgeff[1] = 1'b0;
    a = 1;
    for (int i = NSTAGE-1; i >= 0; i--) begin
      e.al[i] = !e.sv[i] || (e_rgeff[i] && a);
      a = e.al[i];
    end
    e_al = e.al; e_sv = e.sv;
    exp_q.push_back(e);
  endtask

  task automatic model_step();
    inst_t ns[NSTAGE];
    bit    nv[NSTAGE];
    if (c_rst) begin
      for (int i = 0; i < NSTAGE; i++) m_v[i] = 0;
      return;
    end
    ns = m_slot; nv = m_v;
    for (int i = NSTAGE-1; i >= 1; i--)
      if (e_al[i]) begin
        nv[i] = e_sv[i-1] && e_rgeff[i-1];
        ns[i] = (i == 1) ? if_inst : m_slot[i-1];
      end
    if (c_fl)
      for (int i = 1; i <= FLUSH_DEPTH; i++) nv[i] = 0;
    if (c_ifv && c_rg[0] && e_al[1]) begin
      if (dmode) void'(dir_q.pop_front());
      if_inst = rand_inst();
    end
    m_slot = ns; m_v = nv;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    apply();
  endtask

  task automatic start_dir();
    n_rst = 1; n_ifv = 0; n_fl = 0; n_rg = '1;
    cycle();
    n_rst = 0;
  endtask

  task automatic count_stalls(int ncyc, output int st);
    st = 0;
    for (int k = 0; k < ncyc; k++) begin
      cycle(); #1;
      if (bus.id_stall) st++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("stage_valid", 128'(bus.stage_valid), 128'(mon_e.sv));
        chk("allowin", 128'(bus.allowin), 128'(mon_e.al));
        chk("id_stall", 128'(bus.id_stall), 128'(mon_e.st));
        chk("fwd_hit", 128'({bus.fwd_rs2_hit, bus.fwd_rs1_hit}), 128'({mon_e.h2, mon_e.h1}));
        chk("fwd_data", 128'({bus.fwd_rs2_data, bus.fwd_rs1_data}), 128'({mon_e.d2, mon_e.d1}));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int st;
    dmode = 1; n_ifv = 0; n_rg = '1; n_fl = 0; n_rst = 1;
    for (int i = 0; i < NSTAGE; i++) m_v[i] = 0;
    if_inst = rand_inst();
    bus.if_valid = 0; bus.ready_go = '1; bus.flush = 0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_en = 0; bus.id_rs2_en = 0;
    bus.id_rd = '0; bus.id_rd_we = 0; bus.id_is_load = 0; bus.stage_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    apply();

    // Fill from empty: valids ripple in one stage per cycle.
    start_dir();
    for (int i = 0; i < 6; i++) dir_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    cycle(); #1;
    chk("reset_stage_valid", 128'(bus.stage_valid), 128'(5'b00001));
    chk("reset_allowin", 128'(bus.allowin), 128'(5'b11111));
    chk("reset_stall", 128'(bus.id_stall), 128'(0));
    for (int k = 1; k <= 4; k++) begin
      cycle(); #1;
      chk("fill_stage_valid", 128'(bus.stage_valid), 128'((1 << (k + 1)) - 1));
      chk("fill_allowin", 128'(bus.allowin), 128'(5'b11111));
    end
    count_stalls(4, st);

    // ALU producer then consumer.
    start_dir();
    dir_q.push_back(mk(4, 1, 0, 0, 0, 0, 0));
    dir_q.push_back(mk(0, 0, 0, 4, 1, 0, 0));
    cycle();
    count_stalls(10, st);
`ifdef PIPE_HAZARD_FWD_EN
    chk("alu_use_stalls", 128'(st), 128'(0));
`else
    chk("alu_use_stalls", 128'(st), 128'(3));
`endif

    // Load producer then consumer on rs2.
    start_dir();
    dir_q.push_back(mk(5, 1, 1, 0, 0, 0, 0));
    dir_q.push_back(mk(0, 0, 0, 0, 0, 5, 1));
    cycle();
    count_stalls(10, st);
`ifdef PIPE_HAZARD_FWD_EN
    chk("load_use_stalls", 128'(st), 128'(1));
`else
    chk("load_use_stalls", 128'(st), 128'(3));
`endif

    // r0 destination never creates a dependency.
    start_dir();
    dir_q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    dir_q.push_back(mk(0, 0, 0, 0, 1, 0, 1));
    cycle();
    count_stalls(10, st);
    chk("r0_stalls", 128'(st), 128'(0));

    // Flush while the consumer sits in decode.
    start_dir();
    dir_q.push_back(mk(4, 1, 0, 0, 0, 0, 0));
    dir_q.push_back(mk(0, 0, 0, 4, 1, 0, 0));
    cycle();
    cycle();
    n_fl = 1;
    cycle(); #1;
`ifndef PIPE_HAZARD_FWD_EN
    chk("pre_flush_stall", 128'(bus.id_stall), 128'(1));
`endif
    n_fl = 0;
    cycle(); #1;
    chk("flush_valid1", 128'(bus.stage_valid[1]), 128'(0));
    chk("flush_stall", 128'(bus.id_stall), 128'(0));
    chk("flush_producer_kept", 128'(bus.stage_valid[3]), 128'(1));
    count_stalls(4, st);

    // Randomized traffic.
    start_dir();
    dmode = 0;
    cycle();
    for (int k = 0; k < 4000; k++) begin
      n_ifv = $urandom_range(0, 3) != 0;
      for (int b = 0; b < NSTAGE; b++) n_rg[b] = $urandom_range(0, 7) != 0;
      if ((k % 250) < 4) n_rg[2] = 1'b0;
      n_fl  = $urandom_range(0, 15) == 0;
      n_rst = $urandom_range(0, 299) == 0;
      cycle();
    end

    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drain", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
